// File: rtl/ldpcenc_arb_if.sv
// Requester and encoder handshake bundle for the four-way LDPC encoder input arbiter.
// The master modport is the requester/encoder side; the slave modport is the arbiter.
interface ldpcenc_arb_if;
    logic [3:0]   req_vld;
    logic [3:0]   req_sop;
    logic [15:0]  req_mode;
    logic [107:0] req_data;
    logic [3:0]   req_rdy;
    logic         enc_rdy_in;
    logic         enc_vld_in;
    logic         enc_sop_in;
    logic [3:0]   enc_mode_in;
    logic [26:0]  enc_data_in;
    logic [1:0]   gnt_id;
    logic         busy;
    logic         proto_err;

    modport master (
        output req_vld, req_sop, req_mode, req_data, enc_rdy_in,
        input  req_rdy, enc_vld_in, enc_sop_in, enc_mode_in, enc_data_in,
        input  gnt_id, busy, proto_err
    );

    modport slave (
        input  req_vld, req_sop, req_mode, req_data, enc_rdy_in,
        output req_rdy, enc_vld_in, enc_sop_in, enc_mode_in, enc_data_in,
        output gnt_id, busy, proto_err
    );
endinterface

// File: rtl/ldpcenc_arb.sv
// Four-requester packet arbiter feeding an LDPC encoder; packets are locked for their full length.
// Define LDPCENC_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module ldpcenc_arb (
    input  logic          clk,
    input  logic          rst_n,
    ldpcenc_arb_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [6:0]  cnt, cnt_nxt;
    logic [1:0]  gnt_q, gnt_nxt;
    logic [3:0]  mode_q, mode_nxt;
    logic        drain_first, drain_first_nxt;
    logic [3:0]  cand;
    logic        win_found;
    logic [1:0]  win;
    logic [1:0]  sel;
    logic        accept;
    logic [6:0]  sym;
    logic [6:0]  pkt_len;
    logic [26:0] data_arr [4];
    logic [3:0]  mode_arr [4];
`ifdef LDPCENC_ARB_RR_EN
    logic [1:0]  ptr, ptr_nxt;
`endif

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            data_arr[i] = bus.req_data[27*i +: 27];
            mode_arr[i] = bus.req_mode[4*i +: 4];
        end
    end

    // Scanning downward lets the lowest-priority-offset candidate overwrite the others.
    always_comb begin
        cand      = bus.req_vld & bus.req_sop & {4{bus.enc_rdy_in}};
        win_found = |cand;
        win       = 2'd0;
        for (int k = 3; k >= 0; k--) begin
`ifdef LDPCENC_ARB_RR_EN
            if (cand[ptr + 2'(k)]) win = ptr + 2'(k);
`else
            if (cand[k]) win = 2'(k);
`endif
        end
    end

    always_comb begin
        case (mode_q[1:0])
            2'd0:    sym = 7'd12;
            2'd1:    sym = 7'd16;
            2'd2:    sym = 7'd18;
            default: sym = 7'd20;
        endcase
        case (mode_q[3:2])
            2'd0:    pkt_len = sym;
            2'd1:    pkt_len = sym << 1;
            2'd2:    pkt_len = (sym << 1) + sym;
            default: pkt_len = sym << 2;
        endcase
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        gnt_nxt         = gnt_q;
        mode_nxt        = mode_q;
        drain_first_nxt = drain_first;
`ifdef LDPCENC_ARB_RR_EN
        ptr_nxt         = ptr;
`endif
        bus.req_rdy     = 4'd0;
        bus.enc_vld_in  = 1'b0;
        bus.enc_sop_in  = 1'b0;
        bus.proto_err   = 1'b0;
        bus.enc_mode_in = mode_q;
        sel             = gnt_q;
        accept          = 1'b0;
        case (state)
            IDLE: begin
                sel             = win;
                bus.enc_mode_in = mode_arr[win];
                if (win_found) begin
                    bus.req_rdy[win] = 1'b1;
                    bus.enc_vld_in   = 1'b1;
                    bus.enc_sop_in   = 1'b1;
                    gnt_nxt          = win;
                    mode_nxt         = mode_arr[win];
                    cnt_nxt          = 7'd1;
                    state_nxt        = XFER;
`ifdef LDPCENC_ARB_RR_EN
                    ptr_nxt          = win + 2'd1;
`endif
                end
            end
            XFER: begin
                accept             = bus.req_vld[gnt_q] & bus.enc_rdy_in;
                bus.req_rdy[gnt_q] = bus.enc_rdy_in;
                bus.enc_vld_in     = accept;
                if (accept) begin
                    cnt_nxt       = cnt + 7'd1;
                    bus.proto_err = bus.req_sop[gnt_q];
                    if (cnt + 7'd1 == pkt_len) begin
                        state_nxt       = DRAIN;
                        drain_first_nxt = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drain_first) drain_first_nxt = 1'b0;
                else if (bus.enc_rdy_in) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        bus.enc_data_in = data_arr[sel];
        // Handshake outputs are forced quiet while reset is held, whatever the state register holds.
        if (!rst_n) begin
            bus.req_rdy    = 4'd0;
            bus.enc_vld_in = 1'b0;
            bus.enc_sop_in = 1'b0;
            bus.proto_err  = 1'b0;
        end
        bus.busy   = rst_n && (state != IDLE);
        bus.gnt_id = gnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 7'd0;
            gnt_q       <= 2'd0;
            mode_q      <= 4'd0;
            drain_first <= 1'b0;
`ifdef LDPCENC_ARB_RR_EN
            ptr         <= 2'd0;
`endif
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            gnt_q       <= gnt_nxt;
            mode_q      <= mode_nxt;
            drain_first <= drain_first_nxt;
`ifdef LDPCENC_ARB_RR_EN
            ptr         <= ptr_nxt;
`endif
        end
    end
endmodule

// File: doc/ldpcenc_arb.md
LDPCENC_ARB -- requirements
Module: ldpcenc_arb

Interface
REQ-001 Parameters: none; requester count is fixed at 4.
REQ-002 One clock; reset is synchronous and active-low. Ports: clk, rst_n.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous reset, active low.
REQ-005 req_vld  input  4  per-requester word valid, bit i = requester i.
REQ-006 req_sop  input  4  per-requester start of packet, qualified by req_vld.
REQ-007 req_mode  input  16  per-requester mode, [4i+3:4i]; within each nibble [1:0] = rate, [3:2] = codeword length.
REQ-008 req_data  input  108  per-requester data word, [27i+26:27i].
REQ-009 req_rdy  output  4  per-requester ready; a word is accepted when req_vld[i] & req_rdy[i].
REQ-010 enc_rdy_in  input  1  encoder ready to receive.
REQ-011 enc_vld_in, enc_sop_in  output  1 each  valid and start of packet to the encoder.
REQ-012 enc_mode_in  output  4  mode to the encoder.
REQ-013 enc_data_in  output  27  data to the encoder.
REQ-014 gnt_id  output  2  index of the current or last granted requester.
REQ-015 busy  output  1  high in XFER and DRAIN.
REQ-016 proto_err  output  1  one-cycle pulse on a protocol violation by the granted requester.

Function
REQ-017 FSM states: IDLE, XFER, DRAIN; registered state.
REQ-018 IDLE, candidate set: requesters with req_vld[i] & req_sop[i] & enc_rdy_in; the winner is chosen combinationally the same cycle.
REQ-019 Winner handling: its first word is forwarded that cycle with enc_sop_in=1; gnt_id and mode are registered; word counter is set to 1; next state is XFER.
REQ-020 Packet length N, in words, is symbols × (mode[3:2]+1):
- symbols = 12, 16, 18, 20 for rate 0, 1, 2, 3;
- N is computed from the latched mode;
- counter width is 7 bits; maximum N = 80.
REQ-021 XFER outputs:
- req_rdy[gnt_id] = enc_rdy_in; all other req_rdy bits = 0;
- enc_vld_in = req_vld[gnt_id] & enc_rdy_in;
- enc_sop_in = 0;
- enc_data_in = granted requester's data, zero latency.
REQ-022 XFER counting: each accepted word increments the counter; the word that makes counter == N moves the FSM to DRAIN.
REQ-023 enc_mode_in is driven from the latched mode in XFER and DRAIN, and from the winner's req_mode in IDLE.
REQ-024 Mid-packet sop: req_sop[gnt_id]=1 on an accepted word in XFER is forwarded as data with enc_sop_in=0, and proto_err pulses in that cycle.
REQ-025 DRAIN: enc_vld_in=0 and all req_rdy=0. The first DRAIN cycle is unconditional; after it, the FSM returns to IDLE on the first cycle with enc_rdy_in=1.
REQ-026 IDLE with no winner: enc_vld_in=0 and enc_sop_in=0. A req_vld without req_sop gets no req_rdy (the word is stalled, not dropped).
REQ-027 Requester-side stall during XFER (req_vld=0): no forwarding and no count; no timeout.
REQ-028 gnt_id holds its value in DRAIN and IDLE until the next grant.

Reset
REQ-029 When rst_n=0 at a clk edge, the block SHALL enter the following reset values:
- state = IDLE, counter = 0;
- gnt_id = 0, latched mode = 0;
- priority pointer = 0, busy = 0, proto_err = 0.
REQ-030 During reset, all req_rdy and enc_vld_in/enc_sop_in SHALL be 0.
REQ-031 Reset asserted mid-packet abandons the packet with no completion; the block is in IDLE the cycle after reset is released.

Configuration
REQ-032 Macro LDPCENC_ARB_RR_EN defined: round-robin arbitration.
- Search starts at the priority pointer; after granting i, pointer = (i+1) mod 4.
REQ-033 Macro LDPCENC_ARB_RR_EN undefined: fixed priority, lowest index wins; no pointer register exists.

Verification
REQ-034 Single packet: req0 sop with mode=4'b0000 (N=12), 12 consecutive words, enc_rdy_in=1 -> exactly 12 enc_vld_in, enc_sop_in only on word 1, then DRAIN, busy low once back in IDLE.
REQ-035 Length check: mode=4'b1111 (rate 3, 4 words/symbol) -> N=80 forwarded, and the 81st req word is stalled (req_rdy=0).
REQ-036 Round robin (RR_EN defined): req0..req3 all hold sop continuously -> grant order 0,1,2,3,0; without the macro -> always 0.
REQ-037 Backpressure: enc_rdy_in deasserted for 5 cycles mid-XFER -> no forwarding and no count; the packet completes with the exact N words in order.
REQ-038 Protocol error: granted req1 asserts sop on word 5 -> proto_err one-cycle pulse, word forwarded with enc_sop_in=0, count continues.
REQ-039 Reset mid-XFER after word 7 -> next cycle IDLE with all outputs at reset values; a new sop is then granted normally.
